uart_rx: RTL and testbench

- 16x-oversampled UART receiver. Consumes the single-cycle `tick` strobe from the baud/tick generator and the asynchronous serial line `rx`.
- Recovers LSB-first frames: start bit, DATA_BITS data bits, optional parity, one stop bit.
- Delivers each byte with error flags over a valid/ready handshake to the downstream RX FIFO/host logic.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync.sv | 28 ++
 rtl/uart_rx.sv | 171 +++++++++++++++++
 tb/tb_uart_rx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and oversampling constants.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BRK
   } rx_state_t;

   localparam int unsigned OVERSAMPLE  = 16;
   localparam logic [3:0]  MID_SAMPLE  = 4'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0]  LAST_SAMPLE = 4'(OVERSAMPLE - 1);

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous idle-high line; resets to 1.
module uart_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver with parity/framing checks and a valid/ready output.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned PARITY_EN   = 0,
   parameter int unsigned PARITY_ODD  = 0,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
   localparam logic       PAR_ODD  = (PARITY_ODD != 0);

   logic rx_s;

   rx_state_t            state_q, state_d;
   logic [3:0]           s_cnt_q, s_cnt_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 p_err_q, p_err_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 parity_err_q, parity_err_d;
   logic                 overrun_q, overrun_d;
   logic                 frame_done;

   uart_sync #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (rx),
      .q  (rx_s)
   );

   always_comb begin
      state_d   = state_q;
      s_cnt_d   = s_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      p_err_d   = p_err_q;
      if (tick) begin
         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_d = START;
                  s_cnt_d = '0;
                  p_err_d = 1'b0;
               end
            end
            START: begin
               // Mid start bit: a line back high means the edge was a glitch.
               if (s_cnt_q == MID_SAMPLE) begin
                  s_cnt_d   = '0;
                  bit_cnt_d = '0;
                  state_d   = rx_s ? IDLE : DATA;
               end else begin
                  s_cnt_d = s_cnt_q + 4'd1;
               end
            end
            DATA: begin
               if (s_cnt_q == LAST_SAMPLE) begin
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                  s_cnt_d = '0;
                  if (bit_cnt_q == LAST_BIT) begin
                     state_d = (PARITY_EN != 0) ? PARITY : STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + 4'd1;
               end
            end
            PARITY: begin
               if (s_cnt_q == LAST_SAMPLE) begin
                  p_err_d = ((^shift_q ^ rx_s) != PAR_ODD);
                  s_cnt_d = '0;
                  state_d = STOP;
               end else begin
                  s_cnt_d = s_cnt_q + 4'd1;
               end
            end
            STOP: begin
               if (s_cnt_q == LAST_SAMPLE) begin
                  s_cnt_d = '0;
                  state_d = rx_s ? IDLE : BRK;
               end else begin
                  s_cnt_d = s_cnt_q + 4'd1;
               end
            end
            BRK: begin
               if (rx_s) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign frame_done = tick && (state_q == STOP) && (s_cnt_q == LAST_SAMPLE);

   // Acceptance and a fresh completion can coincide; the new word then wins.
   always_comb begin
      rx_data_d    = rx_data_q;
      rx_valid_d   = rx_valid_q;
      frame_err_d  = frame_err_q;
      parity_err_d = parity_err_q;
      overrun_d    = 1'b0;
      if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
      if (frame_done) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d    = shift_q;
            frame_err_d  = !rx_s;
            parity_err_d = p_err_q;
            rx_valid_d   = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         s_cnt_q      <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         p_err_q      <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         s_cnt_q      <= s_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         p_err_q      <= p_err_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: default framing instance plus an even-parity instance.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick = 1'b0;
   logic       rx0, rx1, rx_ready;
   logic [7:0] rx_data0, rx_data1;
   logic       valid0, valid1, fe0, fe1, pe0, pe1, ov0, ov1, busy0, busy1;

   int unsigned tick_div = 56;
   int unsigned div_cnt  = 0;
   int          tick_num = 0;
   int          errors   = 0;
   int          checks   = 0;

   logic       got, fe, pe, done;
   logic [7:0] d;
   int         t0, tk, w, cnt, vcnt;

   uart_rx u_dut (
      .clk(clk), .rst(rst), .tick(tick), .rx(rx0),
      .rx_data(rx_data0), .rx_valid(valid0), .rx_ready(rx_ready),
      .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .busy(busy0)
   );

   uart_rx #(
      .PARITY_EN (1),
      .PARITY_ODD(0)
   ) u_dut_par (
      .clk(clk), .rst(rst), .tick(tick), .rx(rx1),
      .rx_data(rx_data1), .rx_valid(valid1), .rx_ready(rx_ready),
      .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .busy(busy1)
   );

   always #5 clk = ~clk;

   // Tick changes on the falling edge so it is stable at every rising edge.
   always @(negedge clk) begin
      if (div_cnt >= tick_div - 1) begin
         div_cnt = 0;
         tick    = 1'b1;
      end else begin
         div_cnt++;
         tick = 1'b0;
      end
   end

   always @(posedge clk) if (tick) tick_num++;

   task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      checks++;
      if (got_v !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         do @(posedge clk); while (tick !== 1'b1);
      end
   endtask

   task automatic set_rx(input bit sel, input logic b);
      if (sel) rx1 = b;
      else     rx0 = b;
   endtask

   task automatic send_bit(input bit sel, input logic b, input int n);
      #1;
      set_rx(sel, b);
      wait_ticks(n);
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] data, input bit par_en,
                             input logic par_bit, input logic stop_bit, output int t_start);
      #1;
      t_start = tick_num;
      set_rx(sel, 1'b0);
      wait_ticks(16);
      for (int i = 0; i < 8; i++) send_bit(sel, data[i], 16);
      if (par_en) send_bit(sel, par_bit, 16);
      send_bit(sel, stop_bit, 16);
   endtask

   task automatic capture(input bit sel, input int maxclk, output logic g, output logic [7:0] dat,
                          output logic f, output logic p, output int t, output int width);
      g = 1'b0; dat = '0; f = 1'b0; p = 1'b0; t = 0; width = 0;
      for (int i = 0; i < maxclk; i++) begin
         @(posedge clk); #1;
         if (sel ? valid1 : valid0) begin
            g     = 1'b1;
            dat   = sel ? rx_data1 : rx_data0;
            f     = sel ? fe1 : fe0;
            p     = sel ? pe1 : pe0;
            t     = tick_num;
            width = 1;
            break;
         end
      end
      if (g) begin
         for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (sel ? valid1 : valid0) width++;
            else break;
         end
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; rx_ready = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_valid", valid0, 0);
      check("rst_data", rx_data0, 0);
      check("rst_flags", {fe0, pe0, ov0}, 0);
      check("rst_busy", busy0, 0);
      check("rst_par_valid", valid1, 0);
      rst = 1'b0;

      // 0xA5 at 56 clks per tick, ready held high
      send_bit(0, 1'b1, 4);
      fork
         send_frame(0, 8'hA5, 0, 1'b0, 1'b1, t0);
         capture(0, 200 * 56, got, d, fe, pe, tk, w);
      join
      check("a5_valid", got, 1);
      check("a5_latency", tk - t0, 153);
      check("a5_data", d, 8'hA5);
      check("a5_fe", fe, 0);
      check("a5_pe", pe, 0);
      check("a5_width", w, 1);

      tick_div = 8;
      send_bit(0, 1'b1, 4);

      // 3-tick glitch
      cnt = 0; vcnt = 0;
      fork
         begin
            send_bit(0, 1'b0, 3);
            send_bit(0, 1'b1, 20);
         end
         begin
            for (int i = 0; i < 20; i++) begin
               wait_ticks(1); #2;
               if (busy0) cnt++;
               if (valid0) vcnt++;
            end
         end
      join
      check("glitch_busy_ticks", cnt, 8);
      check("glitch_no_valid", vcnt, 0);

      // 0x3C with stop bit low, then break
      fork
         send_frame(0, 8'h3C, 0, 1'b0, 1'b0, t0);
         capture(0, 200 * 8, got, d, fe, pe, tk, w);
      join
      check("brk_valid", got, 1);
      check("brk_data", d, 8'h3C);
      check("brk_fe", fe, 1);
      send_bit(0, 1'b0, 40);
      #2;
      check("brk_busy_low", busy0, 1);
      send_bit(0, 1'b1, 16);
      #2;
      check("brk_idle_high", busy0, 0);
      fork
         send_frame(0, 8'h55, 0, 1'b0, 1'b1, t0);
         capture(0, 200 * 8, got, d, fe, pe, tk, w);
      join
      check("after_brk_valid", got, 1);
      check("after_brk_data", d, 8'h55);
      check("after_brk_fe", fe, 0);
      check("after_brk_latency", tk - t0, 153);

      // even parity: 0x07 has three ones, so a 0 parity bit is wrong
      send_bit(1, 1'b1, 4);
      fork
         send_frame(1, 8'h07, 1, 1'b0, 1'b1, t0);
         capture(1, 220 * 8, got, d, fe, pe, tk, w);
      join
      check("par_bad_valid", got, 1);
      check("par_bad_data", d, 8'h07);
      check("par_bad_pe", pe, 1);
      check("par_latency", tk - t0, 169);
      send_bit(1, 1'b1, 4);
      fork
         send_frame(1, 8'h07, 1, 1'b1, 1'b1, t0);
         capture(1, 220 * 8, got, d, fe, pe, tk, w);
      join
      check("par_ok_valid", got, 1);
      check("par_ok_pe", pe, 0);
      check("par_ok_fe", fe, 0);

      // overrun with the consumer stalled
      rx_ready = 1'b0;
      send_bit(0, 1'b1, 4);
      fork
         send_frame(0, 8'h11, 0, 1'b0, 1'b1, t0);
         capture(0, 200 * 8, got, d, fe, pe, tk, w);
      join
      check("ovr_first_valid", got, 1);
      check("ovr_first_data", d, 8'h11);
      cnt = 0; done = 1'b0;
      fork
         begin
            send_bit(0, 1'b1, 4);
            send_frame(0, 8'h22, 0, 1'b0, 1'b1, t0);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               if (ov0) cnt++;
            end
         end
      join
      check("ovr_pulses", cnt, 1);
      check("ovr_held_data", rx_data0, 8'h11);
      check("ovr_held_valid", valid0, 1);
      @(negedge clk);
      rx_ready = 1'b1;
      @(posedge clk); #1;
      check("ovr_accept_clears", valid0, 0);

      // reset during bit 4 of 0xF0
      send_bit(0, 1'b1, 4);
      send_bit(0, 1'b0, 16);
      for (int i = 0; i < 4; i++) send_bit(0, 1'b0, 16);
      send_bit(0, 1'b1, 8);
      @(negedge clk);
      check("mid_frame_busy", busy0, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", busy0, 0);
      check("mid_rst_data", rx_data0, 0);
      check("mid_rst_flags", {valid0, fe0, pe0, ov0}, 0);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      send_bit(0, 1'b1, 20);
      fork
         send_frame(0, 8'h81, 0, 1'b0, 1'b1, t0);
         capture(0, 200 * 8, got, d, fe, pe, tk, w);
      join
      check("post_rst_valid", got, 1);
      check("post_rst_data", d, 8'h81);
      check("post_rst_latency", tk - t0, 153);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
